graph_memory_arb: RTL and testbench
===================================

Name: graph_memory_arb

Overview:
- Parametrised, multi-requester successor to the CSR graph store.
- Holds a row-pointer memory and an edge memory (column index/neighbour data) as inferred 2-cycle-latency read-first block RAMs.
- Arbitrates N_REQ processor channels onto one row-pointer read port and two edge read ports every cycle, and returns per-requester responses at fixed latency.
- Adds a host write port for loading and out-of-range error flagging.

Parameters:
- N_REQ, 4, number of requester channels (2..16)
- DATA_WIDTH, 32, word width of both memories
- ADDR_BITS, 36, requester address width (32 + PROC_BITS)
- PTR_DEPTH, 1024, row-pointer memory entries
- EDGE_DEPTH, 1024, edge memory entries
- PTR_INIT, "out_ids2.mem", row-pointer init file (empty = zeros)
- EDGE_INIT, "out_addrs2.mem", edge init file (empty = zeros)

Ports:
- clk_in  in  1  single clock
- rst_in  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-channel request valid
- req_sel  in  N_REQ  per-channel target: 0 = row-pointer, 1 = edge
- req_addr  in  N_REQ*ADDR_BITS  per-channel word address; channel i at [i*ADDR_BITS +: ADDR_BITS]
- req_ready  out  N_REQ  grant; combinational from req_valid/req_sel/wr_* and arbiter state
- resp_valid  out  N_REQ  one-cycle response pulse per channel
- resp_data  out  N_REQ*DATA_WIDTH  per-channel read data
- resp_err  out  N_REQ  response address was out of range
- wr_en  in  1  host write strobe
- wr_sel  in  1  write target: 0 = row-pointer, 1 = edge
- wr_addr  in  ADDR_BITS  write address
- wr_data  in  DATA_WIDTH  write data

Behaviour:
- Reset (async, rst_in=1): resp_valid=0, resp_err=0, resp_data=0, both round-robin pointers=0, all in-flight pipeline valids cleared. Memory contents are not affected. A request granted before reset produces no response.
- Transfer rule: a request is accepted when req_valid[i] && req_ready[i]. Requesters must not make req_valid depend on req_ready. A requester holds req_valid/req_sel/req_addr stable until accepted.
- Row-pointer arbitration: one grant per cycle, to the first valid sel=0 channel at or after rr_ptr (wrapping modulo N_REQ). Then rr_ptr <= granted+1 mod N_REQ. If nothing is granted, rr_ptr is unchanged.
- Edge arbitration: two grants per cycle, to the first two valid sel=1 channels at or after rr_edge (wrapping). The first goes to port A, the second to port B. Then rr_edge <= last granted+1 mod N_REQ.
- Write priority:
  - wr_en with wr_sel=0 blocks all row-pointer grants that cycle.
  - wr_en with wr_sel=1 occupies edge port B, so at most one edge grant (port A).
  - Writes with wr_addr >= target depth are discarded silently.
- Read-first: a read and a write to the same address in the same cycle returns the old data.
- Latency: request accepted on cycle T gives resp_valid[i]=1 on cycle T+2 for exactly one cycle, with resp_data and resp_err. Each channel is granted at most once per cycle, so responses never collide. Back-to-back acceptance on consecutive cycles gives consecutive responses in order. No backpressure on responses.
- Address width: memory index = low clog2(depth) bits. If req_addr >= depth of the selected memory: the access is still granted, resp_err=1, resp_data=0.
- resp_data[i] holds its last value when resp_valid[i]=0. resp_err[i]=0 whenever resp_valid[i]=0.
- Pipeline: granted channel id, port, and err flag travel two stages alongside the BRAM read (address register, then output register).

Test Plan:
- Reset, then idle → resp_valid=0, resp_data=0, req_ready=0. Assert rst_in mid-cycle after a grant → no resp_valid pulse 2 cycles later.
- Channel 0 reads row-pointer addr 5 (init file value 0x0000_0012) → req_ready[0]=1 same cycle; resp_valid[0]=1 and resp_data=0x12 exactly 2 cycles later for 1 cycle.
- Channels 0,1,2 hold edge requests from rr_edge=0 → cycle 1 grants ch0 (A) and ch1 (B); cycle 2 grants ch2; responses at cycles 3,3,4.
- wr_en=1, wr_sel=1, addr 7, data 0xDEAD with an edge read of addr 7 the same cycle → read returns the old value. Read of addr 7 on the next cycle returns 0xDEAD. Edge grants that cycle = 1 only.
- Channel 3 row-pointer read at addr 2000 (PTR_DEPTH=1024) → resp_valid[3]=1, resp_err[3]=1, resp_data=0 at T+2.
- All 4 channels request row-pointer continuously → grants rotate 0,1,2,3,0 on successive cycles. Each resp_valid arrives 2 cycles after its grant.

Source files
------------

// File: rtl/graph_memory_arb.sv
// Multi-requester CSR graph store: row-pointer and edge BRAMs shared by N_REQ channels
// through round-robin arbiters, with a host write port and fixed two-cycle responses.
module graph_memory_arb #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 36,
    parameter int PTR_DEPTH  = 1024,
    parameter int EDGE_DEPTH = 1024,
    parameter     PTR_INIT   = "out_ids2.mem",
    parameter     EDGE_INIT  = "out_addrs2.mem"
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_sel,
    input  logic [N_REQ*ADDR_BITS-1:0]  req_addr,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            resp_valid,
    output logic [N_REQ*DATA_WIDTH-1:0] resp_data,
    output logic [N_REQ-1:0]            resp_err,
    input  logic                        wr_en,
    input  logic                        wr_sel,
    input  logic [ADDR_BITS-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data
);
    localparam int RR_W = $clog2(N_REQ);
    localparam int PA   = $clog2(PTR_DEPTH);
    localparam int EA   = $clog2(EDGE_DEPTH);
    localparam logic [ADDR_BITS-1:0] PTR_LIM  = ADDR_BITS'(PTR_DEPTH);
    localparam logic [ADDR_BITS-1:0] EDGE_LIM = ADDR_BITS'(EDGE_DEPTH);

    // Port numbering used by the pipeline: 0 = row-pointer, 1 = edge A, 2 = edge B.
    logic [N_REQ-1:0][ADDR_BITS-1:0] req_addr_a;
    assign req_addr_a = req_addr;

    logic [RR_W-1:0] rr_ptr_q, rr_ptr_d, rr_edge_q, rr_edge_d, ci;
    logic [2:0]                 gnt_d, s1_vld_q, s1_err_d, s1_err_q, s2_vld_q, s2_err_q;
    logic [2:0][RR_W-1:0]       gnt_id_d, s1_id_q, s2_id_q;
    logic [2:0][ADDR_BITS-1:0]  gnt_addr;
    int                         e_cnt, e_max;

    logic [PA-1:0]         ptr_ra_q, ptr_ra_d, wr_pa_q, wr_pa_d;
    logic [EA-1:0]         ea_ra_q, ea_ra_d, eb_ra_q, eb_ra_d, wr_ea_q, wr_ea_d;
    logic                  wr_ptr_q, wr_ptr_d, wr_edge_q, wr_edge_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] ptr_dout_q, ea_dout_q, eb_dout_q;
    logic [2:0][DATA_WIDTH-1:0]     port_dout;
    logic [N_REQ-1:0][DATA_WIDTH-1:0] resp_hold_q, resp_hold_d;

    logic [DATA_WIDTH-1:0] ptr_mem  [PTR_DEPTH];
    logic [DATA_WIDTH-1:0] edge_mem [EDGE_DEPTH];

    function automatic logic [RR_W-1:0] wrap(input logic [RR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return RR_W'(s);
    endfunction

    always_comb begin
        req_ready = '0;
        gnt_d     = '0;
        gnt_id_d  = '0;
        gnt_addr  = '0;
        rr_ptr_d  = rr_ptr_q;
        rr_edge_d = rr_edge_q;
        e_cnt     = 0;
        ci        = '0;
        // A host edge write borrows port B, leaving a single edge read slot.
        e_max     = (wr_en && wr_sel) ? 1 : 2;
        for (int k = 0; k < N_REQ; k++) begin
            ci = wrap(rr_ptr_q, k);
            if (!gnt_d[0] && !(wr_en && !wr_sel) && req_valid[ci] && !req_sel[ci]) begin
                gnt_d[0]    = 1'b1;
                gnt_id_d[0] = ci;
                gnt_addr[0] = req_addr_a[ci];
                req_ready[ci] = 1'b1;
                rr_ptr_d    = wrap(ci, 1);
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            ci = wrap(rr_edge_q, k);
            if (e_cnt < e_max && req_valid[ci] && req_sel[ci]) begin
                if (e_cnt == 0) begin
                    gnt_d[1]    = 1'b1;
                    gnt_id_d[1] = ci;
                    gnt_addr[1] = req_addr_a[ci];
                end else begin
                    gnt_d[2]    = 1'b1;
                    gnt_id_d[2] = ci;
                    gnt_addr[2] = req_addr_a[ci];
                end
                req_ready[ci] = 1'b1;
                rr_edge_d     = wrap(ci, 1);
                e_cnt         = e_cnt + 1;
            end
        end
    end

    always_comb begin
        s1_err_d[0] = gnt_addr[0] >= PTR_LIM;
        s1_err_d[1] = gnt_addr[1] >= EDGE_LIM;
        s1_err_d[2] = gnt_addr[2] >= EDGE_LIM;
        ptr_ra_d    = gnt_addr[0][PA-1:0];
        ea_ra_d     = gnt_addr[1][EA-1:0];
        eb_ra_d     = gnt_addr[2][EA-1:0];
        // Writes are staged one cycle so they land on the same edge as the reads
        // accepted alongside them, which keeps the read-first ordering.
        wr_ptr_d    = wr_en && !wr_sel && (wr_addr < PTR_LIM);
        wr_edge_d   = wr_en && wr_sel && (wr_addr < EDGE_LIM);
        wr_pa_d     = wr_addr[PA-1:0];
        wr_ea_d     = wr_addr[EA-1:0];
        wr_data_d   = wr_data;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_ptr_q    <= '0;
            rr_edge_q   <= '0;
            s1_vld_q    <= '0;
            s1_id_q     <= '0;
            s1_err_q    <= '0;
            s2_vld_q    <= '0;
            s2_id_q     <= '0;
            s2_err_q    <= '0;
            ptr_ra_q    <= '0;
            ea_ra_q     <= '0;
            eb_ra_q     <= '0;
            wr_ptr_q    <= 1'b0;
            wr_edge_q   <= 1'b0;
            wr_pa_q     <= '0;
            wr_ea_q     <= '0;
            wr_data_q   <= '0;
            resp_hold_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rr_edge_q   <= rr_edge_d;
            s1_vld_q    <= gnt_d;
            s1_id_q     <= gnt_id_d;
            s1_err_q    <= s1_err_d;
            s2_vld_q    <= s1_vld_q;
            s2_id_q     <= s1_id_q;
            s2_err_q    <= s1_err_q;
            ptr_ra_q    <= ptr_ra_d;
            ea_ra_q     <= ea_ra_d;
            eb_ra_q     <= eb_ra_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_edge_q   <= wr_edge_d;
            wr_pa_q     <= wr_pa_d;
            wr_ea_q     <= wr_ea_d;
            wr_data_q   <= wr_data_d;
            resp_hold_q <= resp_hold_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_ptr_q) ptr_mem[wr_pa_q] <= wr_data_q;
        ptr_dout_q <= ptr_mem[ptr_ra_q];
    end

    always_ff @(posedge clk_in) begin
        ea_dout_q <= edge_mem[ea_ra_q];
    end

    always_ff @(posedge clk_in) begin
        if (wr_edge_q) edge_mem[wr_ea_q] <= wr_data_q;
        eb_dout_q <= edge_mem[eb_ra_q];
    end

    assign port_dout = {eb_dout_q, ea_dout_q, ptr_dout_q};

    always_comb begin
        resp_valid  = '0;
        resp_err    = '0;
        resp_hold_d = resp_hold_q;
        for (int p = 0; p < 3; p++) begin
            if (s2_vld_q[p]) begin
                resp_valid[s2_id_q[p]]  = 1'b1;
                resp_err[s2_id_q[p]]    = s2_err_q[p];
                resp_hold_d[s2_id_q[p]] = s2_err_q[p] ? '0 : port_dout[p];
            end
        end
    end

    assign resp_data = resp_hold_d;

endmodule

// File: tb/tb_graph_memory_arb.sv
// Directed bench for graph_memory_arb: a transaction-level model checks every cycle,
// and hand-computed literals pin the key scenarios.
module tb_graph_memory_arb;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AB = 36;
    localparam int PD = 1024;
    localparam int ED = 1024;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [N-1:0]      req_valid, req_sel, req_ready, resp_valid, resp_err;
    logic [N*AB-1:0]   req_addr;
    logic [N*DW-1:0]   resp_data;
    logic              wr_en, wr_sel;
    logic [AB-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;

    int checks = 0;
    int failures = 0;

    graph_memory_arb #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_BITS(AB),
                       .PTR_DEPTH(PD), .EDGE_DEPTH(ED)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid(req_valid), .req_sel(req_sel), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int rr_p, rr_e, cyc = 0;
    logic [N-1:0]         sv [4];
    logic [N-1:0]         se [4];
    logic [DW-1:0]        sd [4][N];
    logic [DW-1:0]        last [N];
    logic [DW-1:0]        pm [int];
    logic [DW-1:0]        em [int];

    always @(negedge clk_in) begin
        logic [N-1:0]    er;
        logic [N*DW-1:0] ed;
        logic [AB-1:0]   a;
        int cur, nxt, n, lim, c;
        if (rst_in) begin
            rr_p = 0;
            rr_e = 0;
            for (int s = 0; s < 4; s++) begin sv[s] = '0; se[s] = '0; end
            for (int i = 0; i < N; i++) last[i] = '0;
            chk("rst_resp_valid", 128'(resp_valid), 128'(0));
            chk("rst_resp_data", 128'(resp_data), 128'(0));
        end else begin
            cur = cyc % 4;
            for (int i = 0; i < N; i++) begin
                if (sv[cur][i]) last[i] = sd[cur][i];
                ed[i*DW +: DW] = last[i];
            end
            chk("model_resp_valid", 128'(resp_valid), 128'(sv[cur]));
            chk("model_resp_err", 128'(resp_err), 128'(se[cur]));
            chk("model_resp_data", 128'(resp_data), 128'(ed));
            sv[cur] = '0;
            se[cur] = '0;

            er = '0;
            if (!(wr_en && !wr_sel)) begin
                for (int k = 0; k < N; k++) begin
                    c = (rr_p + k) % N;
                    if (req_valid[c] && !req_sel[c]) begin
                        er[c] = 1'b1;
                        rr_p = (c + 1) % N;
                        break;
                    end
                end
            end
            lim = (wr_en && wr_sel) ? 1 : 2;
            n = 0;
            for (int k = 0; k < N; k++) begin
                c = (rr_e + k) % N;
                if (n < lim && req_valid[c] && req_sel[c]) begin
                    er[c] = 1'b1;
                    n++;
                    if (n == lim || k == N - 1) ;
                end
            end
            if (n > 0) begin
                // advance past the last edge channel granted this cycle
                for (int k = N - 1; k >= 0; k--) begin
                    c = (rr_e + k) % N;
                    if (er[c] && req_sel[c]) begin rr_e = (c + 1) % N; break; end
                end
            end
            chk("model_req_ready", 128'(req_ready), 128'(er));

            nxt = (cyc + 2) % 4;
            for (int i = 0; i < N; i++) begin
                if (er[i]) begin
                    a = req_addr[i*AB +: AB];
                    sv[nxt][i] = 1'b1;
                    if (a >= (req_sel[i] ? ED : PD)) begin
                        se[nxt][i] = 1'b1;
                        sd[nxt][i] = '0;
                    end else begin
                        se[nxt][i] = 1'b0;
                        sd[nxt][i] = req_sel[i] ? em[int'(a)] : pm[int'(a)];
                    end
                end
            end
            if (wr_en && wr_addr < (wr_sel ? ED : PD)) begin
                if (wr_sel) em[int'(wr_addr)] = wr_data;
                else        pm[int'(wr_addr)] = wr_data;
            end
            cyc++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int ch, input logic v, input logic s, input int addr);
        req_valid[ch] = v;
        req_sel[ch]   = s;
        req_addr[ch*AB +: AB] = AB'(addr);
    endtask

    task automatic host_wr(input logic s, input int addr, input logic [DW-1:0] d);
        tick();
        wr_en   = 1'b1;
        wr_sel  = s;
        wr_addr = AB'(addr);
        wr_data = d;
    endtask

    function automatic logic [DW-1:0] rd(input int ch);
        return resp_data[ch*DW +: DW];
    endfunction

    initial begin
        rst_in = 1'b1;
        req_valid = '0; req_sel = '0; req_addr = '0;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) tick();
        rst_in = 1'b0;
        #1;
        chk("reset_resp_valid", 128'(resp_valid), 128'(0));
        chk("reset_resp_data", 128'(resp_data), 128'(0));
        chk("reset_req_ready", 128'(req_ready), 128'(0));

        // load memories through the host port; the 1024 write must be dropped
        for (int i = 0; i < 4; i++) host_wr(1'b0, i, 32'h100 + 32'(i));
        host_wr(1'b0, 1024, 32'h5555);
        host_wr(1'b0, 5, 32'h12);
        host_wr(1'b1, 7, 32'h0BAD);
        for (int i = 0; i < 4; i++) host_wr(1'b1, 10 + i, 32'h200 + 32'(i));
        tick(); wr_en = 1'b0;
        tick(); tick();

        // single row-pointer read
        tick(); set_req(0, 1, 0, 5); #1;
        chk("ptr_rd_ready", 128'(req_ready), 128'(4'b0001));
        tick(); set_req(0, 0, 0, 0);
        tick(); #1;
        chk("ptr_rd_valid", 128'(resp_valid), 128'(4'b0001));
        chk("ptr_rd_data", 128'(rd(0)), 128'(32'h12));
        tick(); #1;
        chk("ptr_rd_pulse_end", 128'(resp_valid), 128'(0));
        chk("ptr_rd_hold", 128'(rd(0)), 128'(32'h12));

        // three edge requests, two ports
        tick(); set_req(0, 1, 1, 10); set_req(1, 1, 1, 11); set_req(2, 1, 1, 12); #1;
        chk("edge3_ready_c1", 128'(req_ready), 128'(4'b0011));
        tick(); set_req(0, 0, 0, 0); set_req(1, 0, 0, 0); #1;
        chk("edge3_ready_c2", 128'(req_ready), 128'(4'b0100));
        tick(); set_req(2, 0, 0, 0); #1;
        chk("edge3_resp_c3", 128'(resp_valid), 128'(4'b0011));
        chk("edge3_data01", 128'({rd(1), rd(0)}), 128'({32'h201, 32'h200}));
        tick(); #1;
        chk("edge3_resp_c4", 128'(resp_valid), 128'(4'b0100));
        chk("edge3_data2", 128'(rd(2)), 128'(32'h202));

        // row-pointer write blocks row-pointer grants
        host_wr(1'b0, 6, 32'h66); set_req(2, 1, 0, 6); #1;
        chk("ptr_wr_block", 128'(req_ready), 128'(0));
        tick(); wr_en = 1'b0; #1;
        chk("ptr_after_wr_ready", 128'(req_ready), 128'(4'b0100));
        tick(); set_req(2, 0, 0, 0);
        tick(); #1;
        chk("ptr_after_wr_data", 128'(rd(2)), 128'(32'h66));

        // edge write with same-address read: read-first, one edge grant
        host_wr(1'b1, 7, 32'hDEAD); set_req(3, 1, 1, 7); set_req(0, 1, 1, 10); #1;
        chk("edge_wr_ready", 128'(req_ready), 128'(4'b1000));
        tick(); wr_en = 1'b0; #1;
        chk("edge_wr_next_ready", 128'(req_ready), 128'(4'b1001));
        tick(); set_req(0, 0, 0, 0); set_req(3, 0, 0, 0); #1;
        chk("edge_wr_old_valid", 128'(resp_valid), 128'(4'b1000));
        chk("edge_wr_old_data", 128'(rd(3)), 128'(32'h0BAD));
        tick(); #1;
        chk("edge_wr_new_valid", 128'(resp_valid), 128'(4'b1001));
        chk("edge_wr_new_data", 128'({rd(3), rd(0)}), 128'({32'hDEAD, 32'h200}));

        // out-of-range row-pointer read
        tick(); set_req(3, 1, 0, 2000); #1;
        chk("oor_ready", 128'(req_ready), 128'(4'b1000));
        tick(); set_req(3, 0, 0, 0);
        tick(); #1;
        chk("oor_valid", 128'(resp_valid), 128'(4'b1000));
        chk("oor_err", 128'(resp_err), 128'(4'b1000));
        chk("oor_data", 128'(rd(3)), 128'(0));

        // all four channels on row-pointer: rotation 0,1,2,3,0
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 1, 0, i);
        #1; chk("rot_g0", 128'(req_ready), 128'(4'b0001));
        tick(); #1; chk("rot_g1", 128'(req_ready), 128'(4'b0010));
        tick(); #1; chk("rot_g2", 128'(req_ready), 128'(4'b0100));
        tick(); #1; chk("rot_g3", 128'(req_ready), 128'(4'b1000));
        tick(); #1; chk("rot_g4", 128'(req_ready), 128'(4'b0001));
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 0, 0, 0);
        #1;
        chk("rot_resp3", 128'(resp_valid), 128'(4'b1000));
        chk("rot_data3", 128'(rd(3)), 128'(32'h103));
        tick(); #1;
        chk("rot_resp0_wrap", 128'(resp_valid), 128'(4'b0001));
        chk("rot_data0_discard", 128'(rd(0)), 128'(32'h100));

        // reset after a grant kills its response and rewinds the arbiters
        tick(); set_req(1, 1, 0, 1); #1;
        chk("rst_grant_ready", 128'(req_ready), 128'(4'b0010));
        tick(); set_req(1, 0, 0, 0); rst_in = 1'b1; #1;
        chk("rst_mid_valid", 128'(resp_valid), 128'(0));
        tick(); rst_in = 1'b0; #1;
        chk("rst_no_pulse", 128'(resp_valid), 128'(0));
        chk("rst_data_clear", 128'(resp_data), 128'(0));
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 1, 0, i);
        #1; chk("rst_rr_ptr0", 128'(req_ready), 128'(4'b0001));
        tick();
        for (int i = 0; i < 4; i++) set_req(i, 0, 0, 0);
        tick(); #1;
        chk("rst_post_valid", 128'(resp_valid), 128'(4'b0001));
        chk("rst_post_data", 128'(rd(0)), 128'(32'h100));
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
